// File: rtl/lda_pkg.sv
// Shared LDA dimensions, coefficient type and loader state encoding.
// Imported by the loader and the classifier so sizes cannot diverge.
package lda_pkg;

    localparam int         DIMS    = 6;
    localparam int         CLASSES = 3;
    localparam int         NUM_W   = DIMS * CLASSES;
    localparam logic [7:0] LDA_HDR = 8'hA5;

    typedef logic [7:0] coef_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WEIGHTS = 3'd1,
        THRESH  = 3'd2,
        CHECK   = 3'd3,
        COMMIT  = 3'd4
    } ld_state_t;

endpackage

// File: rtl/lda_chk_acc.sv
// 8-bit running-sum accumulator for the frame checksum.
// Only built when LDA_LOADER_CHECKSUM_EN is defined.
`ifdef LDA_LOADER_CHECKSUM_EN
module lda_chk_acc (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] r_sum;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sum <= 8'h00;
        end else if (clr_i) begin
            r_sum <= 8'h00;
        end else if (add_i) begin
            r_sum <= r_sum + data_i;
        end
    end

    assign sum_o = r_sum;

endmodule
`endif

// File: rtl/lda_coef_loader.sv
// LDA coefficient loader: byte-serial frame -> shadow regs -> atomic commit.
// Optional trailing checksum byte enabled by LDA_LOADER_CHECKSUM_EN.
module lda_coef_loader #(
    parameter int         DIMS    = lda_pkg::DIMS,
    parameter int         CLASSES = lda_pkg::CLASSES,
    parameter logic [7:0] HDR     = lda_pkg::LDA_HDR
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    input  logic [7:0]                        s_data_i,
    input  logic                              abort_i,
    output logic [DIMS-1:0][CLASSES-1:0][7:0] w_o,
    output logic [CLASSES-1:0][7:0]           c_o,
    output logic                              coef_valid_o,
    output logic                              load_done_o,
    output logic                              err_o,
    output logic                              busy_o
);
    import lda_pkg::*;

    localparam int NW = DIMS * CLASSES;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = (CLASSES > 1) ? $clog2(CLASSES) : 1;

    ld_state_t           r_state;
    ld_state_t           w_next;
    logic [IW-1:0]       r_idx;
    coef_t [NW-1:0]      r_wsh;
    coef_t [CLASSES-1:0] r_csh;

    logic w_fire;
    logic w_abort;
    logic w_take;
    logic w_last_w;
    logic w_last_c;
    logic w_hdr;

    assign w_fire   = s_valid_i && s_ready_o;
    assign w_abort  = abort_i && (r_state != COMMIT);
    assign w_take   = w_fire && !w_abort;
    assign w_last_w = (r_idx == IW'(NW - 1));
    assign w_last_c = (r_idx == IW'(CLASSES - 1));
    assign w_hdr    = (s_data_i == HDR);

`ifdef LDA_LOADER_CHECKSUM_EN
    logic [7:0] w_sum;
    logic       w_chk_ok;

    lda_chk_acc u_acc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (w_take && (r_state == IDLE)),
        .add_i  (w_take && ((r_state == WEIGHTS) || (r_state == THRESH))),
        .data_i (s_data_i),
        .sum_o  (w_sum)
    );

    // The check byte itself completes the sum; a good frame lands on zero.
    assign w_chk_ok = (8'(w_sum + s_data_i) == 8'h00);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_take && w_hdr) w_next = WEIGHTS;
            end
            WEIGHTS: begin
                if (w_take && w_last_w) w_next = THRESH;
            end
            THRESH: begin
                if (w_take && w_last_c) begin
`ifdef LDA_LOADER_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = COMMIT;
`endif
                end
            end
`ifdef LDA_LOADER_CHECKSUM_EN
            CHECK: begin
                if (w_take) w_next = w_chk_ok ? COMMIT : IDLE;
            end
`endif
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_comb begin
        s_ready_o = (r_state != COMMIT);
        busy_o    = (r_state != IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_idx <= '0;
            r_wsh <= '0;
            r_csh <= '0;
        end else if (w_take) begin
            unique case (r_state)
                IDLE: r_idx <= '0;
                WEIGHTS: begin
                    r_wsh[r_idx] <= s_data_i;
                    r_idx        <= w_last_w ? '0 : r_idx + IW'(1);
                end
                THRESH: begin
                    r_csh[r_idx[CW-1:0]] <= s_data_i;
                    r_idx                <= w_last_c ? '0 : r_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Shadow layout k = i*CLASSES + j matches the packed w_o[i][j] order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            w_o          <= '0;
            c_o          <= '0;
            coef_valid_o <= 1'b0;
            load_done_o  <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            load_done_o <= (r_state == COMMIT);
            if (r_state == COMMIT) begin
                w_o          <= r_wsh;
                c_o          <= r_csh;
                coef_valid_o <= 1'b1;
                err_o        <= 1'b0;
            end else if (w_take && (r_state == IDLE) && !w_hdr) begin
                err_o <= 1'b1;
            end
`ifdef LDA_LOADER_CHECKSUM_EN
            else if (w_take && (r_state == CHECK) && !w_chk_ok) begin
                err_o <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/lda_coef_loader.md
Name: lda_coef_loader

Overview:
Writer side of the LDA classifier's coefficient interface. Accepts a byte-serial frame over a valid/ready stream and assembles the weight matrix and per-class thresholds into shadow registers. Commits them atomically to the active outputs, which drive the classifier's w/c inputs directly. A partial, malformed or aborted frame never disturbs the active coefficients.

Parameters:
DIMS, 6, feature dimensions; must match the classifier.
CLASSES, 3, number of classes; must match the classifier.
HDR, 8'hA5, frame start byte.

Ports:
clk_i  input  1  clock; all logic on the rising edge
rstn_i  input  1  reset, asynchronous, active-low
s_valid_i  input  1  input byte valid
s_ready_o  output  1  loader can accept a byte
s_data_i  input  8  input byte
abort_i  input  1  discard the frame in progress
w_o  output  8 x [DIMS][CLASSES]  active weights, w_o[i][j] = dim i, class j
c_o  output  8 x [CLASSES]  active thresholds
coef_valid_o  output  1  active set has been committed at least once
load_done_o  output  1  one-cycle pulse on commit
err_o  output  1  sticky frame error
busy_o  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset (async assert, synchronous release): state IDLE; w_o, c_o, shadow registers and counters all 0; coef_valid_o, load_done_o and err_o are 0; s_ready_o is 1.
- Handshake: a byte transfers on a rising edge where s_valid_i && s_ready_o. s_ready_o is a function of state only and is 0 only in COMMIT.
- Frame format: HDR, then DIMS*CLASSES weight bytes, then CLASSES threshold bytes, then an optional checksum byte (see feature).
- Weight byte k (0-based) is stored to shadow w[k / CLASSES][k % CLASSES]. Threshold byte m is stored to shadow c[m].
- IDLE: a byte equal to HDR clears the index and goes to WEIGHTS. Any other byte is dropped, sets err_o, and the state stays IDLE.
- WEIGHTS: the index counts from 0 to DIMS*CLASSES-1. After the last weight byte, go to THRESH with the index cleared.
- THRESH: the index counts from 0 to CLASSES-1. After the last threshold byte, go to CHECK if the feature is enabled, otherwise to COMMIT.
- COMMIT: lasts exactly one cycle. On the edge leaving COMMIT: w_o/c_o are loaded from shadow, coef_valid_o is set to 1, and err_o is cleared. load_done_o is high for the cycle following that edge. The next state is IDLE.
- Latency: last payload byte accepted at edge N, then active outputs and load_done_o change at edge N+1.
- The active outputs change only in COMMIT. They are stable for every other cycle, including during the next frame.
- abort_i high at an edge in any state other than COMMIT: next state is IDLE, and a byte handshaking in that same cycle is consumed and ignored. err_o is unchanged and active outputs are untouched.
- abort_i high during COMMIT is ignored; the commit completes.
- There are no gaps or timeouts. s_valid_i may be low for any number of cycles mid-frame.
- Reset mid-frame: all state, including active outputs, is cleared as described for reset.

Optional Feature:
Macro: LDA_LOADER_CHECKSUM_EN.
- Defined:
  - State CHECK accepts one byte.
  - The 8-bit sum modulo 256 of all weight bytes, threshold bytes and the check byte must equal 0. HDR is excluded from the sum.
  - Pass goes to COMMIT.
  - Fail sets err_o, goes to IDLE and does not commit.
- Not defined: CHECK does not exist, no checksum byte is sent, and THRESH goes directly to COMMIT.

Decomposition:
- Package lda_pkg: DIMS, CLASSES, coef_t (logic [7:0]), LDA_HDR, the loader state enum (IDLE, WEIGHTS, THRESH, CHECK, COMMIT), and NUM_W = DIMS*CLASSES.
- The classifier imports the same package so the dimensions cannot diverge.
- One sub-module, lda_chk_acc: an 8-bit running-sum accumulator with clear and add, instantiated only under the macro.

Test Plan:
- Full frame: HDR, 18 x 8'h01, then 8'h10, 8'h20, 8'h30, then checksum 8'h8E when enabled, with s_valid_i held high. Required: every w_o element = 8'h01, c_o = {10,20,30}, load_done_o pulses once one cycle after the last byte, coef_valid_o = 1, s_ready_o is low for exactly 1 cycle.
- Weight ordering: weight byte k = k. Required: w_o[2][1] = 7 and w_o[5][2] = 17.
- Bad header: byte 8'h3C while in IDLE. Required: err_o = 1, busy_o stays 0, outputs unchanged. A following valid frame clears err_o.
- Abort: after a committed set, start a new frame and assert abort_i after 5 weight bytes. Required: state returns to IDLE, old w_o/c_o are retained, no load_done_o pulse. A following full frame loads correctly.
- Backpressure: random s_valid_i gaps, including a single-cycle gap at every position in the frame. Required: identical result to the gap-free case.
- With the macro defined: checksum 8'h8F. Required: err_o = 1, no commit, old coefficients retained. Then checksum 8'h8E. Required: commit occurs and err_o = 0.
